parking_lot_top: RTL and testbench

- Controller for a 7-floor automated parking lot served by a single elevator. Floor 0 is the entrance/exit.
- Each floor has one sedan place and one SUV place.
- Accepts entry/exit requests tagged with a 4-digit BCD plate, parks and retrieves cars one at a time, and computes the exit fee.
- On a water-leakage alarm, relocates cars away from the leaking floor.
- Top-level block; drives display and debug outputs.

---
 rtl/parking_lot_pkg.sv | 20 ++
 rtl/parking_lot_req_fifo.sv | 39 +++
 rtl/parking_lot_top.sv | 230 +++++++++++++++++++++++
 tb/tb_parking_lot_top.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/parking_lot_pkg.sv
// parking_lot_pkg: shared states, widths and plate helpers for the parking lot controller
package parking_lot_pkg;
  localparam int NUM_FLOORS = 7;
  localparam int FLOOR_W = 3;
  localparam int PLACE_W = 1;
  localparam logic [3:0] SUV_DIGIT = 4'd8;
  typedef logic [15:0] plate_t;
  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_UP_LOADED   = 3'd1,
    S_RETURN      = 3'd2,
    S_FETCH       = 3'd3,
    S_DOWN_LOADED = 3'd4,
    S_LEAK_FETCH  = 3'd5,
    S_LEAK_CARRY  = 3'd6
  } state_t;
  function automatic logic is_suv(plate_t p);
    return p[15:12] >= SUV_DIGIT;
  endfunction
endpackage

// File: rtl/parking_lot_req_fifo.sv
// parking_lot_req_fifo: show-ahead request queue of {entry flag, plate}; pushes while full are dropped
module parking_lot_req_fifo #(
  parameter int DEPTH = 8,
  parameter int W = 17
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  logic do_push, do_pop;
  assign full = cnt == (AW+1)'(DEPTH);
  assign empty = cnt == '0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign dout = mem[rp];
  always_ff @(posedge clock) begin
    if (!reset) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      if (do_push) begin
        mem[wp] <= din;
        wp <= (wp == AW'(DEPTH-1)) ? '0 : wp + 1'b1;
      end
      if (do_pop) rp <= (rp == AW'(DEPTH-1)) ? '0 : rp + 1'b1;
      cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/parking_lot_top.sv
// parking_lot_top: seven-floor single-elevator parking controller with leak relocation
// PARKING_LOT_FEE_EN builds entry timestamps for time-based fees; otherwise every exit costs FEE_BASE
module parking_lot_top
  import parking_lot_pkg::*;
#(
  parameter int QUEUE_DEPTH = 8,
  parameter int FEE_BASE = 10,
  parameter int FEE_PER_CYCLE = 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [15:0]        license_plate,
  input  logic               in_mode,
  input  logic               out_mode,
  input  logic               leakage,
  input  logic [FLOOR_W-1:0] leakage_floor,
  output logic [31:0]        parked_1,
  output logic [31:0]        parked_2,
  output logic [31:0]        parked_3,
  output logic [31:0]        parked_4,
  output logic [31:0]        parked_5,
  output logic [31:0]        parked_6,
  output logic [31:0]        parked_7,
  output logic [FLOOR_W-1:0] current_floor,
  output logic [15:0]        moving,
  output logic               plate_type,
  output logic [7:0]         fee,
  output logic [3:0]         empty_suv,
  output logic [3:0]         empty_sedan,
  output logic               full_suv,
  output logic               full_sedan,
  output logic               in_mode_internal,
  output logic               out_mode_internal,
  output logic [15:0]        license_plate_internal,
  output logic [2:0]         curr_state_for_test,
  output logic [FLOOR_W-1:0] target_floor,
  output logic [PLACE_W-1:0] target_place
);
  state_t state, state_n;
  plate_t slot [8][2];
  plate_t head_plate;
  logic [16:0] head;
  logic [FLOOR_W-1:0] leak_r, dest, free_fl, hit_fl, excl_fl;
  logic [7:0] fee_next;
  logic head_in, q_empty, q_full, pop, push, want, excl_en, free_ok, hit_ok, hit_pl;
  logic pick_pl, pick_ok, leak_occ, leak_go, leak_again, arrived, accept_in, accept_out;
`ifdef PARKING_LOT_FEE_EN
  logic [15:0] cnt, moving_ts, dur;
  logic [15:0] ts [8][2];
  logic [31:0] fee_full;
  assign dur = cnt - moving_ts;
  assign fee_full = 32'(FEE_BASE) + 32'(FEE_PER_CYCLE) * {16'd0, dur};
  assign fee_next = (fee_full > 32'd255) ? 8'd255 : fee_full[7:0];
`else
  assign fee_next = 8'(FEE_BASE);
`endif
  parking_lot_req_fifo #(.DEPTH(QUEUE_DEPTH), .W(17)) u_fifo (
    .clock(clock),
    .reset(reset),
    .push(push),
    .din({in_mode, license_plate}),
    .pop(pop),
    .dout(head),
    .full(q_full),
    .empty(q_empty)
  );
  assign push = (in_mode ^ out_mode) && license_plate != '0 && !q_full;
  assign head_in = head[16];
  assign head_plate = head[15:0];
  assign dest = (state == S_RETURN || state == S_DOWN_LOADED || state == S_IDLE) ? '0 : target_floor;
  assign arrived = current_floor == dest;
  // floor 0 slots are never written, so a zero leak floor reads as unoccupied
  assign leak_occ = slot[leakage_floor][0] != '0 || slot[leakage_floor][1] != '0;
  assign leak_go = leakage && leak_occ;
  assign leak_again = leakage && (leak_occ || leakage_floor == target_floor);
  assign pick_pl = slot[leak_r][0] == '0;
  assign pick_ok = slot[leak_r][pick_pl] != '0;
  assign want = (state == S_LEAK_FETCH) ? pick_pl : is_suv(head_plate);
  assign excl_en = (state == S_LEAK_FETCH) || leakage;
  assign excl_fl = (state == S_LEAK_FETCH) ? leak_r : leakage_floor;
  assign accept_in = head_in && free_ok && !hit_ok;
  assign accept_out = !head_in && hit_ok;
  always_comb begin
    free_ok = 1'b0;
    free_fl = '0;
    hit_ok = 1'b0;
    hit_fl = '0;
    hit_pl = 1'b0;
    empty_suv = '0;
    empty_sedan = '0;
    for (int f = NUM_FLOORS; f >= 1; f--) begin
      empty_sedan = empty_sedan + 4'(slot[f][0] == '0);
      empty_suv = empty_suv + 4'(slot[f][1] == '0);
      if (slot[f][want] == '0 && !(excl_en && excl_fl == FLOOR_W'(f))) begin
        free_ok = 1'b1;
        free_fl = FLOOR_W'(f);
      end
      for (int p = 0; p < 2; p++)
        if (head_plate != '0 && slot[f][p] == head_plate) begin
          hit_ok = 1'b1;
          hit_fl = FLOOR_W'(f);
          hit_pl = 1'(p);
        end
    end
  end
  always_comb begin
    state_n = state;
    pop = 1'b0;
    unique case (state)
      S_IDLE:
        if (leak_go) state_n = S_LEAK_FETCH;
        else if (!q_empty) begin
          pop = 1'b1;
          state_n = accept_in ? S_UP_LOADED : accept_out ? S_FETCH : S_IDLE;
        end
      S_UP_LOADED:   state_n = arrived ? S_RETURN : state;
      S_RETURN:      state_n = arrived ? S_IDLE : state;
      S_FETCH:       state_n = arrived ? S_DOWN_LOADED : state;
      S_DOWN_LOADED: state_n = arrived ? S_IDLE : state;
      S_LEAK_FETCH:  state_n = !arrived ? state : (pick_ok && free_ok) ? S_LEAK_CARRY : S_RETURN;
      S_LEAK_CARRY:  state_n = !arrived ? state : leak_again ? S_LEAK_FETCH : S_RETURN;
      default:       state_n = S_IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (!reset) state <= S_IDLE;
    else state <= state_n;
  end
  always_ff @(posedge clock) begin
    if (!reset) begin
      current_floor <= '0;
      moving <= '0;
      fee <= '0;
      leak_r <= '0;
      target_floor <= '0;
      target_place <= '0;
      in_mode_internal <= 1'b0;
      out_mode_internal <= 1'b0;
      license_plate_internal <= '0;
      for (int f = 0; f < 8; f++)
        for (int p = 0; p < 2; p++) slot[f][p] <= '0;
`ifdef PARKING_LOT_FEE_EN
      cnt <= '0;
      moving_ts <= '0;
      for (int f = 0; f < 8; f++)
        for (int p = 0; p < 2; p++) ts[f][p] <= '0;
`endif
    end else begin
      if (!arrived) current_floor <= (dest > current_floor) ? current_floor + 1'b1 : current_floor - 1'b1;
`ifdef PARKING_LOT_FEE_EN
      cnt <= cnt + 1'b1;
`endif
      case (state)
        S_IDLE:
          if (leak_go) begin
            leak_r <= leakage_floor;
            target_floor <= leakage_floor;
            target_place <= slot[leakage_floor][0] == '0;
          end else if (pop) begin
            in_mode_internal <= head_in;
            out_mode_internal <= !head_in;
            license_plate_internal <= head_plate;
            if (accept_in) begin
              moving <= head_plate;
              target_floor <= free_fl;
              target_place <= is_suv(head_plate);
            end else if (accept_out) begin
              target_floor <= hit_fl;
              target_place <= hit_pl;
            end
          end
        S_UP_LOADED:
          if (arrived) begin
            slot[target_floor][target_place] <= moving;
            moving <= '0;
`ifdef PARKING_LOT_FEE_EN
            ts[target_floor][target_place] <= cnt;
`endif
          end
        S_FETCH:
          if (arrived) begin
            moving <= slot[target_floor][target_place];
            slot[target_floor][target_place] <= '0;
`ifdef PARKING_LOT_FEE_EN
            moving_ts <= ts[target_floor][target_place];
`endif
          end
        S_DOWN_LOADED:
          if (arrived) begin
            fee <= fee_next;
            moving <= '0;
          end
        S_LEAK_FETCH:
          if (arrived && pick_ok && free_ok) begin
            moving <= slot[leak_r][pick_pl];
            slot[leak_r][pick_pl] <= '0;
            target_floor <= free_fl;
            target_place <= pick_pl;
`ifdef PARKING_LOT_FEE_EN
            moving_ts <= ts[leak_r][pick_pl];
`endif
          end
        S_LEAK_CARRY:
          if (arrived) begin
            slot[target_floor][target_place] <= moving;
            moving <= '0;
`ifdef PARKING_LOT_FEE_EN
            ts[target_floor][target_place] <= moving_ts;
`endif
            if (leak_again) begin
              leak_r <= leakage_floor;
              target_floor <= leakage_floor;
            end
          end
        default: ;
      endcase
    end
  end
  assign parked_1 = {slot[1][0], slot[1][1]};
  assign parked_2 = {slot[2][0], slot[2][1]};
  assign parked_3 = {slot[3][0], slot[3][1]};
  assign parked_4 = {slot[4][0], slot[4][1]};
  assign parked_5 = {slot[5][0], slot[5][1]};
  assign parked_6 = {slot[6][0], slot[6][1]};
  assign parked_7 = {slot[7][0], slot[7][1]};
  assign full_suv = empty_suv == '0;
  assign full_sedan = empty_sedan == '0;
  assign plate_type = is_suv(license_plate_internal);
  assign curr_state_for_test = state;
endmodule

// File: tb/tb_parking_lot_top.sv
// tb_parking_lot_top: directed scoreboard bench for the parking lot controller
module tb_parking_lot_top;
  logic clock = 1'b0;
  logic reset = 1'b0;
  logic [15:0] license_plate = '0;
  logic in_mode = 1'b0;
  logic out_mode = 1'b0;
  logic leakage = 1'b0;
  logic [2:0] leakage_floor = '0;
  logic [31:0] parked_1, parked_2, parked_3, parked_4, parked_5, parked_6, parked_7;
  logic [2:0] current_floor, curr_state_for_test, target_floor;
  logic [15:0] moving, license_plate_internal;
  logic [7:0] fee;
  logic [3:0] empty_suv, empty_sedan;
  logic plate_type, full_suv, full_sedan, in_mode_internal, out_mode_internal;
  logic [0:0] target_place;
  int passed = 0, failed = 0, total = 0, cyc = 0, step_bad = 0;
  int prev_floor = 0;
`ifdef PARKING_LOT_FEE_EN
  int t_in = 0, t_out = 0;
`endif
  typedef struct {
    string tag;
    logic [15:0] plate;
    int fl;
    int pl;
  } exp_t;
  exp_t sb[$];

  parking_lot_top dut (
    .clock(clock), .reset(reset), .license_plate(license_plate), .in_mode(in_mode),
    .out_mode(out_mode), .leakage(leakage), .leakage_floor(leakage_floor),
    .parked_1(parked_1), .parked_2(parked_2), .parked_3(parked_3), .parked_4(parked_4),
    .parked_5(parked_5), .parked_6(parked_6), .parked_7(parked_7),
    .current_floor(current_floor), .moving(moving), .plate_type(plate_type), .fee(fee),
    .empty_suv(empty_suv), .empty_sedan(empty_sedan), .full_suv(full_suv), .full_sedan(full_sedan),
    .in_mode_internal(in_mode_internal), .out_mode_internal(out_mode_internal),
    .license_plate_internal(license_plate_internal), .curr_state_for_test(curr_state_for_test),
    .target_floor(target_floor), .target_place(target_place)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    cyc++;
    #1;
    if (reset && (int'(current_floor) - prev_floor > 1 || prev_floor - int'(current_floor) > 1)) step_bad++;
    prev_floor = int'(current_floor);
  end

`ifdef PARKING_LOT_FEE_EN
  always @(negedge clock)
    if (t_in == 0 && parked_2[15:0] == 16'h8754) t_in = cyc;
`endif

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] slot_of(int f, int p);
    logic [31:0] w;
    case (f)
      1: w = parked_1;
      2: w = parked_2;
      3: w = parked_3;
      4: w = parked_4;
      5: w = parked_5;
      6: w = parked_6;
      7: w = parked_7;
      default: w = '0;
    endcase
    return p != 0 ? w[15:0] : w[31:16];
  endfunction

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check(e.tag, slot_of(e.fl, e.pl), e.plate);
    end
  endtask

  task automatic drive(logic i, logic o, logic [15:0] p);
    in_mode = i;
    out_mode = o;
    license_plate = p;
    @(negedge clock);
    in_mode = 1'b0;
    out_mode = 1'b0;
    license_plate = '0;
  endtask

  task automatic wait_idle(string tag);
    int run = 0;
    for (int i = 0; i < 2000 && run < 12; i++) begin
      @(negedge clock);
      run = (curr_state_for_test == 3'd0) ? run + 1 : 0;
    end
    check(tag, run, 12);
  endtask

  task automatic wait_state(string tag, logic [2:0] st);
    int n = 0;
    while (curr_state_for_test !== st && n < 200) begin
      @(negedge clock);
      n++;
    end
    check(tag, curr_state_for_test, st);
  endtask

  task automatic wait_moving(string tag, logic [15:0] p);
    int n = 0;
    while (moving !== p && n < 200) begin
      @(negedge clock);
      n++;
    end
    check(tag, moving, p);
  endtask

  task automatic check_reset(string tag);
    check({tag, "_parked"}, parked_1 | parked_2 | parked_3 | parked_4 | parked_5 | parked_6 | parked_7, 0);
    check({tag, "_floor"}, current_floor, 0);
    check({tag, "_empty"}, {empty_suv, empty_sedan}, 8'h77);
    check({tag, "_full"}, {full_suv, full_sedan}, 0);
    check({tag, "_state"}, curr_state_for_test, 0);
    check({tag, "_moving_fee"}, {moving, fee}, 0);
    check({tag, "_debug"}, {in_mode_internal, out_mode_internal, license_plate_internal, target_floor, target_place}, 0);
  endtask

  initial begin
    logic [7:0] exp_fee;
    @(negedge clock);
    check_reset("reset");
    reset = 1'b1;
    @(negedge clock);
    drive(1'b1, 1'b0, 16'h9423);
    @(negedge clock);
    check("first_state", curr_state_for_test, 3'd1);
    check("first_moving", moving, 16'h9423);
    check("first_target", {target_floor, target_place, plate_type, in_mode_internal}, {3'd1, 1'b1, 1'b1, 1'b1});
    drive(1'b1, 1'b0, 16'h8754);
    @(negedge clock);
    drive(1'b1, 1'b0, 16'h9706);
    @(negedge clock);
    drive(1'b1, 1'b0, 16'h2666);
    @(negedge clock);
    drive(1'b1, 1'b0, 16'h7723);
    sb.push_back('{"park_9423", 16'h9423, 1, 1});
    sb.push_back('{"park_8754", 16'h8754, 2, 1});
    sb.push_back('{"park_9706", 16'h9706, 3, 1});
    sb.push_back('{"park_2666", 16'h2666, 1, 0});
    sb.push_back('{"park_7723", 16'h7723, 2, 0});
    wait_idle("entries_idle");
    drain();
    check("entries_empty", {empty_suv, empty_sedan}, 8'h45);
    check("entries_home", {current_floor, moving}, 0);
    leakage_floor = 3'd1;
    leakage = 1'b1;
    wait_state("leak1_carry", 3'd6);
    check("leak1_moving", moving, 16'h2666);
    check("leak1_target", {target_floor, target_place}, {3'd3, 1'b0});
    leakage = 1'b0;
    wait_idle("leak1_idle");
    sb.push_back('{"leak1_moved", 16'h2666, 3, 0});
    sb.push_back('{"leak1_src", 16'h0000, 1, 0});
    sb.push_back('{"leak1_kept", 16'h9423, 1, 1});
    drain();
    leakage = 1'b1;
    wait_state("leak2_carry", 3'd6);
    check("leak2_moving", moving, 16'h9423);
    check("leak2_target", {target_floor, target_place}, {3'd4, 1'b1});
    wait_idle("leak2_idle");
    leakage = 1'b0;
    sb.push_back('{"leak2_moved", 16'h9423, 4, 1});
    sb.push_back('{"leak2_src", 16'h0000, 1, 1});
    drain();
    @(negedge clock);
    drive(1'b0, 1'b1, 16'h8754);
    @(negedge clock);
    check("exit_fetch", {curr_state_for_test, target_floor, target_place, out_mode_internal}, {3'd3, 3'd2, 1'b1, 1'b1});
    wait_moving("exit_pickup", 16'h8754);
    check("exit_pickup_floor", current_floor, 2);
    check("exit_place_cleared", parked_2[15:0], 0);
    wait_moving("exit_delivered", 16'h0000);
`ifdef PARKING_LOT_FEE_EN
    t_out = cyc;
    exp_fee = (10 + t_out - t_in > 255) ? 8'd255 : 8'(10 + t_out - t_in);
`else
    exp_fee = 8'd10;
`endif
    check("exit_floor", current_floor, 0);
    check("exit_fee", fee, exp_fee);
    wait_idle("exit_idle");
    drive(1'b1, 1'b1, 16'h1234);
    @(negedge clock);
    drive(1'b0, 1'b1, 16'h5555);
    @(negedge clock);
    drive(1'b1, 1'b0, 16'h9706);
    @(negedge clock);
    drive(1'b1, 1'b0, 16'h0000);
    wait_idle("discard_idle");
    check("discard_empty", {empty_suv, empty_sedan}, 8'h55);
    check("discard_parked_3", parked_3, 32'h2666_9706);
    check("fee_held", fee, exp_fee);
    reset = 1'b0;
    @(negedge clock);
    check_reset("reset2");
    reset = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clock);
      drive(1'b1, 1'b0, 16'h8000 + 16'(k));
      sb.push_back('{"suv_fill", 16'h8000 + 16'(k), k, 1});
    end
    @(negedge clock);
    drive(1'b1, 1'b0, 16'h8008);
    wait_idle("fill_idle");
    check("fill_flags", {full_suv, full_sedan, empty_suv, empty_sedan}, {1'b1, 1'b0, 4'd0, 4'd7});
    check("fill_no_sedan", parked_1[31:16] | parked_2[31:16] | parked_3[31:16] | parked_4[31:16]
          | parked_5[31:16] | parked_6[31:16] | parked_7[31:16], 0);
    drain();
    check("floor_steps", step_bad, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
